// File: rtl/aq_sysio_mkid.sv
// ---------------------------------------------------------------------------------------------
// aq_sysio_mkid: multi-hart system-IO kid between the PLIC/CLINT/pad domain and up to eight
// C906 cores.
//
// Per hart h:
//   - retimes six interrupt lines (me/se/ms/ss/mt/st) on the APB clock-enable;
//   - drives a constant hart ID of HART_BASE+h;
//   - runs a low-power-mode (LPMD) handshake FSM that forwards the core's LPMD request to the
//     pad on the AXI clock-enable, and aborts or exits low-power mode when an interrupt for
//     that hart is pending.
//
// Parameters:
//   HART_NUM  number of harts served (1..8)
//   HART_BASE hart ID reported by hart 0
//   HARTID_W  hart ID width; HART_BASE+HART_NUM-1 must fit
//
// Ports:
//   forever_cpuclk       free-running CPU clock, the only clock
//   cpurst_b             asynchronous active-low reset
//   pad_yy_icg_scan_en   scan enable, forces both internal clock gates open
//   apb_clk_en           interrupt-path sample strobe
//   axim_clk_en          LPMD-path sample strobe
//   plic_core_*_int,
//   clint_core_*_int     raw interrupts, bit h = hart h
//   core_sysio_lpmd_b    core LPMD request, [2h+1:2h] = hart h, 2'b11 = run
//   core_pad_lpmd_b      registered LPMD to pad
//   sysio_core_*_int     retimed interrupts
//   sysio_core_hartid    constant hart IDs, slice h = HART_BASE+h
//   sysio_core_wakeup    one-cycle pulse when hart h leaves LPM because of an interrupt
//
// Build option:
//   SYSIO_INT_SYNC_EN    when defined, every interrupt input first passes a 2-flop synchronizer
//                        on the ungated clock (for asynchronous interrupt sources).
// ---------------------------------------------------------------------------------------------
module aq_sysio_mkid #(
  parameter int unsigned HART_NUM  = 1,
  parameter int unsigned HART_BASE = 0,
  parameter int unsigned HARTID_W  = 3
) (
  input  logic                         forever_cpuclk,
  input  logic                         cpurst_b,
  input  logic                         pad_yy_icg_scan_en,
  input  logic                         apb_clk_en,
  input  logic                         axim_clk_en,
  input  logic [HART_NUM-1:0]          plic_core_me_int,
  input  logic [HART_NUM-1:0]          plic_core_se_int,
  input  logic [HART_NUM-1:0]          clint_core_ms_int,
  input  logic [HART_NUM-1:0]          clint_core_ss_int,
  input  logic [HART_NUM-1:0]          clint_core_mt_int,
  input  logic [HART_NUM-1:0]          clint_core_st_int,
  input  logic [2*HART_NUM-1:0]        core_sysio_lpmd_b,
  output logic [2*HART_NUM-1:0]        core_pad_lpmd_b,
  output logic [HART_NUM-1:0]          sysio_core_me_int,
  output logic [HART_NUM-1:0]          sysio_core_se_int,
  output logic [HART_NUM-1:0]          sysio_core_ms_int,
  output logic [HART_NUM-1:0]          sysio_core_ss_int,
  output logic [HART_NUM-1:0]          sysio_core_mt_int,
  output logic [HART_NUM-1:0]          sysio_core_st_int,
  output logic [HARTID_W*HART_NUM-1:0] sysio_core_hartid,
  output logic [HART_NUM-1:0]          sysio_core_wakeup
);

  localparam int unsigned IntW = 6 * HART_NUM;

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StReq  = 2'd1,
    StLpm  = 2'd2,
    StWake = 2'd3
  } lpmd_state_e;

  // The two gated clocks are realised as enables on forever_cpuclk; scan enable opens the gate
  // exactly as it would on an integrated clock-gating cell.
  logic int_clk_en;
  logic lpmd_clk_en;

  assign int_clk_en  = apb_clk_en | pad_yy_icg_scan_en;
  assign lpmd_clk_en = axim_clk_en | pad_yy_icg_scan_en;

  // -------------------------------------------------------------------------------------------
  // Interrupt retiming
  // -------------------------------------------------------------------------------------------
  logic [IntW-1:0] int_in;
  logic [IntW-1:0] int_cap;
  logic [IntW-1:0] int_q;

  assign int_in = {plic_core_me_int, plic_core_se_int, clint_core_ms_int,
                   clint_core_ss_int, clint_core_mt_int, clint_core_st_int};

`ifdef SYSIO_INT_SYNC_EN
  logic [IntW-1:0] sync1_q;
  logic [IntW-1:0] sync2_q;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= int_in;
      sync2_q <= sync1_q;
    end
  end

  assign int_cap = sync2_q;
`else
  assign int_cap = int_in;
`endif

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      int_q <= '0;
    end else if (int_clk_en) begin
      int_q <= int_cap;
    end
  end

  assign {sysio_core_me_int, sysio_core_se_int, sysio_core_ms_int,
          sysio_core_ss_int, sysio_core_mt_int, sysio_core_st_int} = int_q;

  // Pending uses the retimed values so the FSM sees the same interrupt state as the core.
  logic [HART_NUM-1:0] pend;

  assign pend = sysio_core_me_int | sysio_core_se_int | sysio_core_ms_int |
                sysio_core_ss_int | sysio_core_mt_int | sysio_core_st_int;

  // -------------------------------------------------------------------------------------------
  // Per-hart hart ID and LPMD handshake
  // -------------------------------------------------------------------------------------------
  for (genvar h = 0; h < HART_NUM; h++) begin : g_hart
    lpmd_state_e state_q, state_d;
    logic [1:0]  pad_q, pad_d;
    logic [1:0]  req_val;
    logic        req;
    logic        wake_q, wake_d;

    assign sysio_core_hartid[h*HARTID_W +: HARTID_W] = HARTID_W'(HART_BASE + h);

    assign req_val = core_sysio_lpmd_b[2*h +: 2];
    assign req     = (req_val != 2'b11);

    always_comb begin
      state_d = state_q;
      pad_d   = pad_q;
      wake_d  = 1'b0;
      unique case (state_q)
        StRun: begin
          pad_d = 2'b11;
          // A pending interrupt vetoes a new request in the same cycle.
          if (req && !pend[h]) begin
            state_d = StReq;
          end
        end
        StReq: begin
          // Abort before the pad is touched: interrupt first, then request withdrawal.
          if (pend[h] || !req) begin
            state_d = StRun;
          end else if (lpmd_clk_en) begin
            pad_d   = req_val;
            state_d = StLpm;
          end
        end
        StLpm: begin
          // Interrupt wins over a simultaneous request drop so the wakeup is still signalled.
          if (pend[h]) begin
            state_d = StWake;
            wake_d  = 1'b1;
          end else if (!req) begin
            state_d = StWake;
          end else if (lpmd_clk_en) begin
            pad_d = req_val;
          end
        end
        StWake: begin
          if (lpmd_clk_en) begin
            pad_d   = 2'b11;
            state_d = StRun;
          end
        end
        default: begin
          state_d = StRun;
          pad_d   = 2'b11;
        end
      endcase
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
        state_q <= StRun;
        pad_q   <= 2'b11;
        wake_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        pad_q   <= pad_d;
        wake_q  <= wake_d;
      end
    end

    assign core_pad_lpmd_b[2*h +: 2] = pad_q;
    assign sysio_core_wakeup[h]      = wake_q;
  end

endmodule

// File: tb/tb_aq_sysio_mkid.sv
// ---------------------------------------------------------------------------------------------
// Bench for aq_sysio_mkid with HART_NUM=4, HART_BASE=2, HARTID_W=3.
// A behavioural model of the retiming and LPMD handshake is compared against every DUT output
// on each falling edge; directed scenarios add hand-computed literal checks.
// ---------------------------------------------------------------------------------------------
module tb_aq_sysio_mkid;
  localparam int unsigned HN = 4;
  localparam int unsigned HB = 2;
  localparam int unsigned HW = 3;

  localparam int MRun   = 0;
  localparam int MReq   = 1;
  localparam int MSleep = 2;
  localparam int MWake  = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic scan_en = 1'b0;
  logic apb_en  = 1'b0;
  logic axim_en = 1'b0;
  logic [HN-1:0] me = '0, se = '0, ms = '0, ss = '0, mt = '0, st = '0;
  logic [2*HN-1:0] lpmd_in = '1;
  logic [2*HN-1:0] pad;
  logic [HN-1:0] o_me, o_se, o_ms, o_ss, o_mt, o_st, wakeup;
  logic [HW*HN-1:0] hartid;

  always #5 clk = ~clk;

  aq_sysio_mkid #(
    .HART_NUM (HN),
    .HART_BASE(HB),
    .HARTID_W (HW)
  ) dut (
    .forever_cpuclk    (clk),
    .cpurst_b          (rst_n),
    .pad_yy_icg_scan_en(scan_en),
    .apb_clk_en        (apb_en),
    .axim_clk_en       (axim_en),
    .plic_core_me_int  (me),
    .plic_core_se_int  (se),
    .clint_core_ms_int (ms),
    .clint_core_ss_int (ss),
    .clint_core_mt_int (mt),
    .clint_core_st_int (st),
    .core_sysio_lpmd_b (lpmd_in),
    .core_pad_lpmd_b   (pad),
    .sysio_core_me_int (o_me),
    .sysio_core_se_int (o_se),
    .sysio_core_ms_int (o_ms),
    .sysio_core_ss_int (o_ss),
    .sysio_core_mt_int (o_mt),
    .sysio_core_st_int (o_st),
    .sysio_core_hartid (hartid),
    .sysio_core_wakeup (wakeup)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int apb_per = 1;
  int axim_per = 1;
  int pulses;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Strobe generator: cyc counts rising edges; the strobe is set up for edge cyc+1.
  always @(posedge clk) begin
    #1;
    cyc++;
    apb_en  = (apb_per != 0) && (((cyc + 1) % apb_per) == 0);
    axim_en = (axim_per != 0) && (((cyc + 1) % axim_per) == 0);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_mod(input int m, input int r);
    for (int k = 0; k < 16 && (cyc % m) != r; k++) tick();
  endtask

  // ---------------------------------------------------------------- model
  logic [5:0][HN-1:0] cur_in, out_vec, m_int, m_s1, m_s2;
  logic [HN-1:0][1:0] m_pad;
  logic [HN-1:0]      m_wake;
  logic [HN-1:0]      m_pend;
  logic [1:0]         m_want;
  int                 m_mode[HN];
  logic [HN-1:0][HW-1:0] exp_hid;

  assign cur_in  = {me, se, ms, ss, mt, st};
  assign out_vec = {o_me, o_se, o_ms, o_ss, o_mt, o_st};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_int  = '0;
      m_s1   = '0;
      m_s2   = '0;
      m_pad  = '1;
      m_wake = '0;
      for (int h = 0; h < HN; h++) m_mode[h] = MRun;
    end else begin
      m_pend = '0;
      for (int i = 0; i < 6; i++) m_pend = m_pend | m_int[i];
`ifdef SYSIO_INT_SYNC_EN
      if (apb_en || scan_en) m_int = m_s2;
      m_s2 = m_s1;
      m_s1 = cur_in;
`else
      if (apb_en || scan_en) m_int = cur_in;
`endif
      for (int h = 0; h < HN; h++) begin
        m_want    = lpmd_in[2*h +: 2];
        m_wake[h] = 1'b0;
        if (m_mode[h] == MRun) begin
          if (m_want != 2'b11 && !m_pend[h]) m_mode[h] = MReq;
        end else if (m_mode[h] == MReq) begin
          if (m_pend[h] || m_want == 2'b11) m_mode[h] = MRun;
          else if (axim_en || scan_en) begin
            m_pad[h]  = m_want;
            m_mode[h] = MSleep;
          end
        end else if (m_mode[h] == MSleep) begin
          if (m_pend[h]) begin
            m_mode[h] = MWake;
            m_wake[h] = 1'b1;
          end else if (m_want == 2'b11) m_mode[h] = MWake;
          else if (axim_en || scan_en) m_pad[h] = m_want;
        end else begin
          if (axim_en || scan_en) begin
            m_pad[h]  = 2'b11;
            m_mode[h] = MRun;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("ints", out_vec, m_int);
    chk("pad", pad, m_pad);
    chk("wakeup", wakeup, m_wake);
    chk("hartid", hartid, exp_hid);
  end

  // ---------------------------------------------------------------- directed stimulus
  initial begin
    for (int h = 0; h < HN; h++) exp_hid[h] = HW'(HB + h);
    rst_n = 1'b0;

    // Reset with random inputs and all strobes active.
    for (int k = 0; k < 3; k++) begin
      me = HN'($urandom); se = HN'($urandom); ms = HN'($urandom);
      ss = HN'($urandom); mt = HN'($urandom); st = HN'($urandom);
      lpmd_in = 8'($urandom);
      tick();
    end
    chk("rst_ints", out_vec, 0);
    chk("rst_pad", pad, 8'hff);
    chk("rst_wakeup", wakeup, 0);
    for (int h = 0; h < HN; h++) chk("rst_hartid", hartid[h*HW +: HW], HB + h);

    me = '0; se = '0; ms = '0; ss = '0; mt = '0; st = '0;
    lpmd_in = '1;
    apb_per = 4;
    axim_per = 2;
    rst_n = 1'b1;
    repeat (6) tick();

    // Interrupt latency: raise just after a strobe edge, output rises on the next strobe edge.
    wait_mod(4, 0);
    mt[1] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k < 4) chk("mt_early", o_mt[1], 1'b0);
      else chk("mt_rise", o_mt[1], 1'b1);
    end
    mt[1] = 1'b0;
    repeat (8) tick();
    chk("mt_fall", o_mt[1], 1'b0);

    // LPMD entry on hart 0.
    lpmd_in[1:0] = 2'b01;
    tick();
    chk("entry_first_edge", pad[1:0], 2'b11);
    for (int k = 0; k < 6 && pad[1:0] != 2'b01; k++) tick();
    chk("entry_pad", pad[1:0], 2'b01);
    chk("entry_other_pad", pad[3:2], 2'b11);

    // Interrupt wakeup from LPM.
    me[0] = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (wakeup[0]) pulses++;
    end
    chk("wake_pulses", pulses, 1);
    chk("wake_pad", pad[1:0], 2'b11);
    lpmd_in[1:0] = 2'b11;
    me[0] = 1'b0;
    repeat (8) tick();

    // Abort in REQ with the AXI strobe idle.
    axim_per = 0;
    repeat (2) tick();
    lpmd_in[1:0] = 2'b00;
    repeat (2) tick();
    ms[0] = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (wakeup[0]) pulses++;
    end
    chk("abort_pad", pad[1:0], 2'b11);
    chk("abort_pulses", pulses, 0);
    axim_per = 2;
    repeat (4) tick();
    chk("abort_in_run", pad[1:0], 2'b11);
    ms[0] = 1'b0;
    lpmd_in[1:0] = 2'b11;
    repeat (8) tick();

    // Hart 3: interrupt and request drop arrive together in LPM -> pulse still asserted.
    lpmd_in[7:6] = 2'b00;
    for (int k = 0; k < 6 && pad[7:6] != 2'b00; k++) tick();
    chk("h3_lpm", pad[7:6], 2'b00);
    wait_mod(4, 0);
    st[3] = 1'b1;
    repeat (4) tick();
    lpmd_in[7:6] = 2'b11;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (wakeup[3]) pulses++;
    end
    chk("h3_simul_pulses", pulses, 1);
    chk("h3_pad", pad[7:6], 2'b11);
    st[3] = 1'b0;
    repeat (8) tick();

    // Asynchronous reset while hart 2 sits in LPM.
    axim_per = 1;
    lpmd_in[5:4] = 2'b10;
    for (int k = 0; k < 6 && pad[5:4] != 2'b10; k++) tick();
    chk("h2_lpm", pad[5:4], 2'b10);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_pad", pad, 8'hff);
    chk("async_wakeup", wakeup, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_run", pad[5:4], 2'b11);
    tick();
    chk("post_rst_lpm", pad[5:4], 2'b10);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
